// File: rtl/efpga_access_ctrl.sv
// Round-robin arbiter and sequencer sharing one eFPGA custom-op datapath between two requesters.
// Latency: accept in cycle 0, strobe in cycle 1, WAIT from cycle 2, rsp_valid in cycle 3+delay (or at timeout).
// Backpressure: req_ready_o only in IDLE and only for the winner; responses are one-cycle pulses with no stall.
module efpga_access_ctrl #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [1:0]            req_valid_i,
   output logic [1:0]            req_ready_o,
   input  logic [2*DATA_W-1:0]   req_operand_a_i,
   input  logic [2*DATA_W-1:0]   req_operand_b_i,
   input  logic [3:0]            req_operator_i,
   input  logic [7:0]            req_delay_i,
   output logic [1:0]            rsp_valid_o,
   output logic                  rsp_err_o,
   output logic [DATA_W-1:0]     rsp_result_a_o,
   output logic [DATA_W-1:0]     rsp_result_b_o,
   output logic [DATA_W-1:0]     rsp_result_c_o,
   output logic                  busy_o,
   output logic [DATA_W-1:0]     eFPGA_operand_a_o,
   output logic [DATA_W-1:0]     eFPGA_operand_b_o,
   output logic [1:0]            eFPGA_operator_o,
   output logic [3:0]            eFPGA_delay_o,
   output logic                  eFPGA_en_o,
   output logic                  eFPGA_write_strobe_o,
   input  logic                  eFPGA_fpga_done_i,
   input  logic [DATA_W-1:0]     eFPGA_result_a_i,
   input  logic [DATA_W-1:0]     eFPGA_result_b_i,
   input  logic [DATA_W-1:0]     eFPGA_result_c_i
);

   localparam int TO_W = $clog2(TIMEOUT + 1);
   // Last WAIT cycle index before a forced completion.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e              state_q, state_d;
   logic                last_gnt_q, last_gnt_d;
   logic                port_q, port_d;
   logic [3:0]          dly_cnt_q, dly_cnt_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [DATA_W-1:0]   opa_q, opa_d;
   logic [DATA_W-1:0]   opb_q, opb_d;
   logic [1:0]          oper_q, oper_d;
   logic [3:0]          delay_q, delay_d;
   logic                en_q, en_d;
   logic                stb_q, stb_d;
   logic [1:0]          rsp_vld_q, rsp_vld_d;
   logic                rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]   res_a_q, res_a_d;
   logic [DATA_W-1:0]   res_b_q, res_b_d;
   logic [DATA_W-1:0]   res_c_q, res_c_d;

   logic                win_vld;
   logic                win_port;
   logic                done_ok;
   logic                to_hit;

   // Round-robin pick: a lone requester wins, otherwise the port that was not granted last.
   always_comb begin
      win_vld  = |req_valid_i;
      win_port = 1'b0;
      case (req_valid_i)
         2'b10:   win_port = 1'b1;
         2'b11:   win_port = ~last_gnt_q;
         default: win_port = 1'b0;
      endcase
      req_ready_o = 2'b00;
      if (state_q == IDLE && win_vld) begin
         req_ready_o = win_port ? 2'b10 : 2'b01;
      end
   end

   // Next-state and datapath computation for the sequencer.
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      port_d     = port_q;
      dly_cnt_d  = dly_cnt_q;
      to_cnt_d   = to_cnt_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      oper_d     = oper_q;
      delay_d    = delay_q;
      en_d       = en_q;
      stb_d      = stb_q;
      rsp_vld_d  = rsp_vld_q;
      rsp_err_d  = rsp_err_q;
      res_a_d    = res_a_q;
      res_b_d    = res_b_q;
      res_c_d    = res_c_q;
      done_ok    = (dly_cnt_q == 4'd0) && eFPGA_fpga_done_i;
      to_hit     = (to_cnt_q == TO_LAST);
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d    = ISSUE;
               port_d     = win_port;
               last_gnt_d = win_port;
               opa_d      = win_port ? req_operand_a_i[2*DATA_W-1:DATA_W] : req_operand_a_i[DATA_W-1:0];
               opb_d      = win_port ? req_operand_b_i[2*DATA_W-1:DATA_W] : req_operand_b_i[DATA_W-1:0];
               oper_d     = win_port ? req_operator_i[3:2] : req_operator_i[1:0];
               delay_d    = win_port ? req_delay_i[7:4] : req_delay_i[3:0];
               en_d       = 1'b1;
               stb_d      = 1'b1;
            end
         end
         ISSUE: begin
            state_d   = WAIT;
            stb_d     = 1'b0;
            dly_cnt_d = delay_q;
            to_cnt_d  = '0;
         end
         WAIT: begin
            if (dly_cnt_q != 4'd0) begin
               dly_cnt_d = dly_cnt_q - 4'd1;
            end
            to_cnt_d = to_cnt_q + TO_W'(1);
            // A real completion beats a coincident timeout.
            if (done_ok || to_hit) begin
               state_d   = RESP;
               en_d      = 1'b0;
               rsp_vld_d = port_q ? 2'b10 : 2'b01;
               rsp_err_d = ~done_ok;
               res_a_d   = eFPGA_result_a_i;
               res_b_d   = eFPGA_result_b_i;
               res_c_d   = eFPGA_result_c_i;
            end
         end
         RESP: begin
            state_d   = IDLE;
            rsp_vld_d = 2'b00;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset drops any in-flight operation and hands first grant to port 0.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         port_q     <= 1'b0;
         dly_cnt_q  <= '0;
         to_cnt_q   <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         oper_q     <= '0;
         delay_q    <= '0;
         en_q       <= 1'b0;
         stb_q      <= 1'b0;
         rsp_vld_q  <= 2'b00;
         rsp_err_q  <= 1'b0;
         res_a_q    <= '0;
         res_b_q    <= '0;
         res_c_q    <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         port_q     <= port_d;
         dly_cnt_q  <= dly_cnt_d;
         to_cnt_q   <= to_cnt_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         oper_q     <= oper_d;
         delay_q    <= delay_d;
         en_q       <= en_d;
         stb_q      <= stb_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_err_q  <= rsp_err_d;
         res_a_q    <= res_a_d;
         res_b_q    <= res_b_d;
         res_c_q    <= res_c_d;
      end
   end

   assign busy_o               = (state_q != IDLE);
   assign rsp_valid_o          = rsp_vld_q;
   assign rsp_err_o            = rsp_err_q;
   assign rsp_result_a_o       = res_a_q;
   assign rsp_result_b_o       = res_b_q;
   assign rsp_result_c_o       = res_c_q;
   assign eFPGA_operand_a_o    = opa_q;
   assign eFPGA_operand_b_o    = opb_q;
   assign eFPGA_operator_o     = oper_q;
   assign eFPGA_delay_o        = delay_q;
   assign eFPGA_en_o           = en_q;
   assign eFPGA_write_strobe_o = stb_q;

endmodule

// File: doc/efpga_access_ctrl.md
Name: efpga_access_ctrl

Overview:
Arbiter and sequencer for the shared eFPGA custom-operation datapath. Two requesters share one eFPGA: port 0 is the ibex_core custom-op path and port 1 is the external/management path. The block grants one request at a time with round-robin priority. It drives the eFPGA operand, operator, delay, enable and strobe lines, waits for completion or timeout, then returns the three eFPGA results to the winning port.

Parameters:
DATA_W, 32, operand/result width
TIMEOUT, 255, max WAIT cycles before forced completion with error (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous reset, active-low
req_valid_i  in  2  request valid, bit n = port n
req_ready_o  out  2  request accept; a transfer occurs when valid[n] & ready[n] are both high
req_operand_a_i  in  2*DATA_W  port n operand A at [n*DATA_W +: DATA_W]
req_operand_b_i  in  2*DATA_W  port n operand B, same packing
req_operator_i  in  4  port n operator at [2n+1:2n]
req_delay_i  in  8  port n minimum latency at [4n+3:4n]
rsp_valid_o  out  2  one-cycle response pulse to port n
rsp_err_o  out  1  response was a timeout; valid only with rsp_valid_o
rsp_result_a_o/rsp_result_b_o/rsp_result_c_o  out  DATA_W each  captured eFPGA results
busy_o  out  1  high in any state other than IDLE
eFPGA_operand_a_o, eFPGA_operand_b_o  out  DATA_W  operands to eFPGA
eFPGA_operator_o  out  2  operator select
eFPGA_delay_o  out  4  latency hint
eFPGA_en_o  out  1  eFPGA enable
eFPGA_write_strobe_o  out  1  operation start strobe
eFPGA_fpga_done_i  in  1  eFPGA completion
eFPGA_result_a_i/eFPGA_result_b_i/eFPGA_result_c_i  in  DATA_W each  eFPGA results

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. All state is updated on the rising edge of clk_i.
- Reset (rst_ni=0 at an edge, including mid-operation): state goes to IDLE. Every output register clears to 0 (eFPGA_*, rsp_*). last_gnt is set to 1 so that port 0 wins first. Counters clear. An in-flight operation is dropped with no response.
- IDLE:
  - req_ready_o is combinational and is asserted only for the winner.
  - With a single valid port, that port wins.
  - With both ports valid, the winner is the port != last_gnt.
  - On transfer, latch the winner's operands, operator, delay and port id, update last_gnt, and go to ISSUE.
  - req_ready_o=0 in all other states.
- ISSUE (1 cycle):
  - eFPGA_write_strobe_o=1 and eFPGA_en_o=1.
  - Load dly_cnt with the latched delay and clear to_cnt.
  - Go to WAIT.
- WAIT:
  - eFPGA_en_o=1 and eFPGA_write_strobe_o=0.
  - dly_cnt decrements each cycle while >0.
  - to_cnt increments each cycle.
  - Normal completion: dly_cnt==0 & eFPGA_fpga_done_i. Capture results and set err=0.
  - Timeout: to_cnt==TIMEOUT-1 without completion. Capture results and set err=1.
  - If completion and timeout happen in the same cycle, completion wins (err=0).
  - On either completion or timeout, go to RESP.
- RESP (1 cycle):
  - rsp_valid_o[port]=1 with results and err.
  - eFPGA_en_o=0.
  - Go to IDLE; a new grant is possible on the next cycle.
- eFPGA_operand/operator/delay outputs are registered from the latched request. They are stable from ISSUE through RESP and hold their last value in IDLE.
- rsp_result_* hold their last value after the RESP pulse.
- eFPGA_fpga_done_i is ignored outside WAIT.
- Latency (accept in cycle 0): strobe in cycle 1, WAIT from cycle 2. Earliest completion is in cycle 2+D (D = delay), giving rsp_valid in cycle 3+D. Minimum accept-to-accept spacing is 4 cycles.
- Arithmetic: dly_cnt is 4 bits and saturates at 0 (no wrap). to_cnt is $clog2(TIMEOUT+1) bits.
- A requester may drop valid before being granted; no state is affected.

Test Plan:
- Reset then single port 0 request (A=0x5, B=0x3, op=2, D=0), done high in the first WAIT cycle, results 0x8/0x2/0xF: accept cycle 0, strobe cycle 1, rsp_valid_o=2'b01 in cycle 3 with results 0x8/0x2/0xF and err=0.
- Port 1 request with D=3 and done held high throughout: completion not before dly_cnt reaches 0; rsp_valid_o=2'b10 exactly in cycle 6.
- Both ports valid continuously for 4 operations: grants alternate 0,1,0,1, and each gets its own response with the matching operands visible on eFPGA_operand_a_o.
- Done never asserted, TIMEOUT=8: rsp_valid pulses with err=1 after 8 WAIT cycles; the next request is accepted normally.
- Done asserts in the same cycle as the timeout: err=0.
- rst_ni low during WAIT: next cycle busy_o=0, eFPGA_en_o=0, no rsp_valid. After reset release, port 0 wins when both ports are valid.
